// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the five-stage RV32 core.
// Handles stall/flush/redirect, variable-latency imem, and two performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_f_i,
    input  logic        stall_d_i,
    input  logic        flush_d_i,
    input  logic        pc_src_e_i,
    input  logic [31:0] pc_target_e_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_ready_i,
    output logic [31:0] instr_d_o,
    output logic [31:0] pc_d_o,
    output logic [31:0] pc_plus4_d_o,
    output logic        valid_d_o,
    output logic        fetch_busy_o,
    output logic        misaligned_o,
    output logic [31:0] instr_count_o,
    output logic [15:0] wait_count_o
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {StBoot, StRun} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_f_q, pc_f_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_dq, pc_dd;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        mis_q, mis_d;
    logic [31:0] icnt_q, icnt_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic        run;
    logic        load;

    assign run  = (state_q == StRun);
    // Data is only accepted when the PC it belongs to is not being redirected away.
    assign load = run & imem_ready_i & ~stall_f_i & ~pc_src_e_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StBoot;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot:  state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StBoot;
        endcase
    end

    always_comb begin
        pc_f_d = pc_f_q;
        mis_d  = mis_q;
        if (run) begin
            if (pc_src_e_i) begin
                pc_f_d = {pc_target_e_i[31:2], 2'b00};
                if (pc_target_e_i[1:0] != 2'b00) begin
                    mis_d = 1'b1;
                end
            end else if (!stall_f_i && imem_ready_i) begin
                pc_f_d = pc_f_q + 32'd4;
            end
        end
    end

    always_comb begin
        instr_d = NOP;
        pc_dd   = 32'h0;
        pc4_d   = 32'h0;
        valid_d = 1'b0;
        icnt_d  = icnt_q;
        if (flush_d_i) begin
            instr_d = NOP;
        end else if (stall_d_i) begin
            instr_d = instr_q;
            pc_dd   = pc_dq;
            pc4_d   = pc4_q;
            valid_d = valid_q;
        end else if (load) begin
            instr_d = imem_rdata_i;
            pc_dd   = pc_f_q;
            pc4_d   = pc_f_q + 32'd4;
            valid_d = 1'b1;
            icnt_d  = icnt_q + 32'd1;
        end
    end

    always_comb begin
        wcnt_d = wcnt_q;
        if (fetch_busy_o && wcnt_q != 16'hFFFF) begin
            wcnt_d = wcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_f_q  <= RESET_PC;
            instr_q <= NOP;
            pc_dq   <= 32'h0;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            icnt_q  <= 32'h0;
            wcnt_q  <= 16'h0;
        end else begin
            pc_f_q  <= pc_f_d;
            instr_q <= instr_d;
            pc_dq   <= pc_dd;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
            icnt_q  <= icnt_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign imem_req_o    = run;
    assign imem_addr_o   = pc_f_q;
    assign fetch_busy_o  = run & ~imem_ready_i;
    assign instr_d_o     = instr_q;
    assign pc_d_o        = pc_dq;
    assign pc_plus4_d_o  = pc4_q;
    assign valid_d_o     = valid_q;
    assign misaligned_o  = mis_q;
    assign instr_count_o = icnt_q;
    assign wait_count_o  = wcnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized self-checking bench for fetch_stage against a cycle-level reference model.
// A second instance starts near the top of the address space to exercise PC wrap.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0, pc_src = 1'b0;
    logic [31:0] pc_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_ready = 1'b1;
    logic [31:0] instr_d, pc_d, pc_plus4_d;
    logic        valid_d, fetch_busy, misaligned;
    logic [31:0] instr_count;
    logic [15:0] wait_count;

    logic        rst_w = 1'b0;
    logic        w_req, w_valid, w_busy, w_mis;
    logic [31:0] w_addr, w_instr, w_pc, w_pc4, w_icnt;
    logic [15:0] w_wcnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic        m_run;
    logic [31:0] m_pc, m_instr, m_pcd, m_pc4;
    logic        m_valid, m_mis;
    logic [31:0] m_icnt;
    int          m_wcnt;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk_i(clk), .rst_i(rst), .stall_f_i(stall_f), .stall_d_i(stall_d),
        .flush_d_i(flush_d), .pc_src_e_i(pc_src), .pc_target_e_i(pc_target),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata),
        .imem_ready_i(imem_ready), .instr_d_o(instr_d), .pc_d_o(pc_d),
        .pc_plus4_d_o(pc_plus4_d), .valid_d_o(valid_d), .fetch_busy_o(fetch_busy),
        .misaligned_o(misaligned), .instr_count_o(instr_count), .wait_count_o(wait_count)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk_i(clk), .rst_i(rst_w), .stall_f_i(1'b0), .stall_d_i(1'b0),
        .flush_d_i(1'b0), .pc_src_e_i(1'b0), .pc_target_e_i(32'h0),
        .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_rdata_i(w_addr ^ 32'hA5A5_A5A5),
        .imem_ready_i(1'b1), .instr_d_o(w_instr), .pc_d_o(w_pc),
        .pc_plus4_d_o(w_pc4), .valid_d_o(w_valid), .fetch_busy_o(w_busy),
        .misaligned_o(w_mis), .instr_count_o(w_icnt), .wait_count_o(w_wcnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_A5A5;
    endfunction

    task automatic model_reset();
        m_run = 1'b0; m_pc = 32'h0; m_instr = 32'h13; m_pcd = 0; m_pc4 = 0;
        m_valid = 1'b0; m_mis = 1'b0; m_icnt = 0; m_wcnt = 0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".instr"}, instr_d, m_instr);
        check({tag, ".pc_d"}, pc_d, m_pcd);
        check({tag, ".pc4"}, pc_plus4_d, m_pc4);
        check({tag, ".valid"}, {31'b0, valid_d}, {31'b0, m_valid});
        check({tag, ".mis"}, {31'b0, misaligned}, {31'b0, m_mis});
        check({tag, ".icnt"}, instr_count, m_icnt);
        check({tag, ".wcnt"}, {16'b0, wait_count}, m_wcnt);
    endtask

    // Called just after a falling edge; spans one rising edge.
    task automatic cycle(input string tag, input logic sf, input logic sd, input logic fl,
                         input logic src, input logic [31:0] tgt, input logic rdy);
        logic accept;
        stall_f = sf; stall_d = sd; flush_d = fl; pc_src = src; pc_target = tgt;
        imem_ready = rdy;
        imem_rdata = mem_word(m_pc);
        #1;
        check({tag, ".req"}, {31'b0, imem_req}, {31'b0, m_run});
        check({tag, ".addr"}, imem_addr, m_pc);
        check({tag, ".busy"}, {31'b0, fetch_busy}, {31'b0, m_run && !rdy});
        accept = m_run && rdy && !sf && !src;
        if (fl) begin
            m_instr = 32'h13; m_pcd = 0; m_pc4 = 0; m_valid = 0;
        end else if (!sd) begin
            if (accept) begin
                m_instr = mem_word(m_pc); m_pcd = m_pc; m_pc4 = m_pc + 4; m_valid = 1;
                m_icnt = m_icnt + 1;
            end else begin
                m_instr = 32'h13; m_pcd = 0; m_pc4 = 0; m_valid = 0;
            end
        end
        if (m_run && !rdy && m_wcnt < 65535) m_wcnt++;
        if (m_run) begin
            if (src) begin
                m_pc = tgt & 32'hFFFF_FFFC;
                if (tgt % 4 != 0) m_mis = 1;
            end else if (!sf && rdy) begin
                m_pc = m_pc + 4;
            end
        end
        m_run = 1'b1;
        @(negedge clk);
        check_regs(tag);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".req"}, {31'b0, imem_req}, 32'h0);
        check({tag, ".addr"}, imem_addr, 32'h0);
        check({tag, ".busy"}, {31'b0, fetch_busy}, 32'h0);
        check_regs(tag);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_values("rst");
        @(negedge clk);
        rst = 1'b0;

        // Zero-wait streaming from reset
        for (int i = 0; i < 4; i++) cycle("stream", 0, 0, 0, 0, 0, 1);
        check("stream.pc_d_8", pc_d, 32'h8);
        check("stream.icnt3", instr_count, 32'd3);
        cycle("stream", 0, 0, 0, 0, 0, 1);
        // Three wait states at PC 0x10
        check("wait.addr10", imem_addr, 32'h10);
        for (int i = 0; i < 3; i++) cycle("wait", 0, 0, 0, 0, 0, 0);
        check("wait.cnt3", {16'b0, wait_count}, 32'd3);
        check("wait.held", imem_addr, 32'h10);
        cycle("wait_rel", 0, 0, 0, 0, 0, 1);
        check("wait.load10", pc_d, 32'h10);
        // Advance to pc_d=0x20, then full stall for 2 cycles
        while (m_pcd != 32'h20) cycle("adv", 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 2; i++) cycle("stall", 1, 1, 0, 0, 0, 1);
        check("stall.hold20", pc_d, 32'h20);
        check("stall.addr24", imem_addr, 32'h24);
        cycle("stall_rel", 0, 0, 0, 0, 0, 1);
        check("stall.pc24", pc_d, 32'h24);
        // Redirect with flush while stall_f is high
        cycle("redir", 1, 0, 1, 1, 32'h100, 1);
        check("redir.addr100", imem_addr, 32'h100);
        check("redir.bubble", {31'b0, valid_d}, 32'h0);
        cycle("redir2", 0, 0, 0, 0, 0, 1);
        check("redir.pc100", pc_d, 32'h100);
        // Misaligned target
        cycle("mis", 0, 0, 1, 1, 32'h203, 1);
        check("mis.addr200", imem_addr, 32'h200);
        check("mis.flag", {31'b0, misaligned}, 32'h1);
        cycle("mis2", 0, 0, 0, 0, 0, 1);
        check("mis.sticky", {31'b0, misaligned}, 32'h1);

        // Fresh reset, then randomized traffic
        rst = 1'b1;
        model_reset();
        #1;
        check_reset_values("rst2");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic sf, sd, fl, src, rdy;
            logic [31:0] tgt;
            sf  = ($urandom_range(0, 7) == 0);
            sd  = ($urandom_range(0, 7) == 0);
            fl  = ($urandom_range(0, 9) == 0);
            src = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            cycle("rand", sf, sd, fl, src, tgt, rdy);
        end

        // Asynchronous reset mid-stream, observed before any clock edge
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        rst = 1'b0;
        cycle("post_rst", 0, 0, 0, 0, 0, 1);

        // PC wrap on the second instance
        rst_w = 1'b1;
        @(negedge clk);
        rst_w = 1'b0;
        check("wrap.boot_addr", w_addr, 32'hFFFF_FFF8);
        check("wrap.boot_req", {31'b0, w_req}, 32'h0);
        @(negedge clk);
        check("wrap.addr0", w_addr, 32'hFFFF_FFF8);
        check("wrap.req", {31'b0, w_req}, 32'h1);
        @(negedge clk);
        check("wrap.addr1", w_addr, 32'hFFFF_FFFC);
        check("wrap.pc_d0", w_pc, 32'hFFFF_FFF8);
        @(negedge clk);
        check("wrap.addr2", w_addr, 32'h0000_0000);
        check("wrap.pc_d1", w_pc, 32'hFFFF_FFFC);
        check("wrap.pc4", w_pc4, 32'h0000_0000);
        #2;
        rst_w = 1'b1;
        #1;
        check("wrap.rst_addr", w_addr, 32'hFFFF_FFF8);
        check("wrap.rst_valid", {31'b0, w_valid}, 32'h0);
        check("wrap.rst_instr", w_instr, 32'h13);
        check("wrap.rst_icnt", w_icnt, 32'h0);
        check("wrap.rst_req", {31'b0, w_req}, 32'h0);
        rst_w = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
